// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and
// the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } subState_e;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cntWidth(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - d_in, with the borrow out in d_out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic d_in,
  output logic diff,
  output logic d_out
);

  assign diff  = a ^ b ^ d_in;
  assign d_out = (~a & b) | (~(a ^ b) & d_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor. A single full_subtractor cell is walked
// across the operands LSB first, producing one result every WIDTH+1 cycles.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = cntWidth(WIDTH);

  subState_e        state_q;
  logic [WIDTH-1:0] shA_q;
  logic [WIDTH-1:0] shB_q;
  logic [WIDTH-1:0] shD_q;
  logic [WIDTH-1:0] shD_d;
  logic             borrow_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrowOut_q;
  logic             busy_q;
  logic             done_q;
  logic             fsDiff;
  logic             fsBout;

  full_subtractor u_fs (
    .a     (shA_q[0]),
    .b     (shB_q[0]),
    .d_in  (borrow_q),
    .diff  (fsDiff),
    .d_out (fsBout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift-and-or so it stays legal when WIDTH is 1.
  assign shD_d = (shD_q >> 1) | (WIDTH'(fsDiff) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shA_q       <= '0;
      shB_q       <= '0;
      shD_q       <= '0;
      borrow_q    <= 1'b0;
      count_q     <= '0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            shA_q    <= a;
            shB_q    <= b;
            borrow_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          shD_q    <= shD_d;
          borrow_q <= fsBout;
          shA_q    <= shA_q >> 1;
          shB_q    <= shB_q >> 1;
          count_q  <= count_q + CNT_W'(1);
          // Last bit: publish the result, including the bit computed this edge.
          if (count_q == CNT_W'(WIDTH - 1)) begin
            diff_q      <= shD_d;
            borrowOut_q <= fsBout;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrowOut_q;

endmodule
